// File: rtl/clock_pkg.sv
// Shared types and constants for the CPU clock-control slice.
// Imported by the top-level clock_control block and by button_debounce.
package clock_pkg;

    localparam int FAST_CLK_HZ      = 12_000_000;
    localparam int DEBOUNCE_DEFAULT = FAST_CLK_HZ / 1000;
    localparam int SYNC_STAGES      = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } debounce_state_t;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw pushbutton.
// Emits one tick per qualified press and a level that is high while the press is held.
module button_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic tick,
    output logic level
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   button_s;
    debounce_state_t        state;
    debounce_state_t        state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   tick_next;

    assign button_s = sync_q[SYNC_STAGES-1];
    assign level    = (state == PRESSED);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            state  <= IDLE;
            cnt    <= '0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button};
            state  <= state_next;
            cnt    <= cnt_next;
            tick   <= tick_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        tick_next  = 1'b0;
        case (state)
            IDLE: begin
                if (button_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!button_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    tick_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!button_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high during release is the same press, not a new one.
                if (button_s) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/clock_control.sv
// CPU clock-enable generator: selects slowClk edges or debounced single-steps,
// applies the sticky HLT gate, and counts delivered CPU clock ticks.
module clock_control
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int COUNT_W         = 16
) (
    input  logic               fastClk,
    input  logic               rst_n,
    input  logic               slowClk,
    input  logic               stepButton,
    input  logic               manualMode,
    input  logic               halt,
    output logic               cpuClkEn,
    output logic               cpuClk,
    output logic               halted,
    output logic [COUNT_W-1:0] tickCount
);

    logic [SYNC_STAGES:0]   slow_q;
    logic [SYNC_STAGES-1:0] mode_q;
    logic                   slow_s;
    logic                   slow_d;
    logic                   manual_s;
    logic                   auto_tick;
    logic                   step_tick;
    logic                   step_level;
    logic                   tick;
    logic                   tick_gated;
    logic                   halt_set;
    logic                   cpu_clk_next;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .clk   (fastClk),
        .rst_n (rst_n),
        .button(stepButton),
        .tick  (step_tick),
        .level (step_level)
    );

    // The extra stage on slowClk provides the previous synchronized value for edge detect.
    assign slow_s     = slow_q[SYNC_STAGES-1];
    assign slow_d     = slow_q[SYNC_STAGES];
    assign manual_s   = mode_q[SYNC_STAGES-1];
    assign auto_tick  = slow_s & ~slow_d;
    assign tick       = manual_s ? step_tick : auto_tick;
    assign tick_gated = tick & ~halted;
    assign halt_set   = cpuClkEn & halt;

    // Halt forces the level low on the same edge halted sets, so the display never lags.
    always_comb begin
        cpu_clk_next = 1'b0;
        if (halted || halt_set) begin
            cpu_clk_next = 1'b0;
        end else if (manual_s) begin
            cpu_clk_next = tick_gated | (cpuClk & step_level);
        end else begin
            cpu_clk_next = slow_s;
        end
    end

    always_ff @(posedge fastClk or negedge rst_n) begin
        if (!rst_n) begin
            slow_q    <= '0;
            mode_q    <= '0;
            cpuClkEn  <= 1'b0;
            cpuClk    <= 1'b0;
            halted    <= 1'b0;
            tickCount <= '0;
        end else begin
            slow_q    <= {slow_q[SYNC_STAGES-1:0], slowClk};
            mode_q    <= {mode_q[SYNC_STAGES-2:0], manualMode};
            cpuClkEn  <= tick_gated;
            cpuClk    <= cpu_clk_next;
            halted    <= halted | halt_set;
            tickCount <= tickCount + COUNT_W'(cpuClkEn);
        end
    end

endmodule

// File: tb/tb_clock_control.sv
// Randomized self-checking bench for clock_control against a spec-level model
// of edge-to-pulse latency, debounce qualification, halt and counter wrap.
module tb_clock_control;

    localparam int DEB  = 4;
    localparam int CW   = 16;
    localparam int CW_N = 8;

    logic            fastClk    = 1'b0;
    logic            rst_n      = 1'b0;
    logic            slowClk    = 1'b0;
    logic            stepButton = 1'b0;
    logic            manualMode = 1'b0;
    logic            halt       = 1'b0;
    logic            cpuClkEn;
    logic            cpuClk;
    logic            halted;
    logic [CW-1:0]   tickCount;
    logic            n_en;
    logic            n_clk;
    logic            n_halted;
    logic [CW_N-1:0] n_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: h[k] is the slowClk value driven k steps ago.
    logic h[4];
    bit   auto_chk;
    bit   m_halted;
    logic prev_en;
    int   streak_hi;
    int   pulses;
    int   exp_pulses;
    int   en_err;
    int   clk_err;
    int   hlt_err;

    clock_control #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(CW)) dut (
        .fastClk   (fastClk),
        .rst_n     (rst_n),
        .slowClk   (slowClk),
        .stepButton(stepButton),
        .manualMode(manualMode),
        .halt      (halt),
        .cpuClkEn  (cpuClkEn),
        .cpuClk    (cpuClk),
        .halted    (halted),
        .tickCount (tickCount)
    );

    clock_control #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(CW_N)) dut_narrow (
        .fastClk   (fastClk),
        .rst_n     (rst_n),
        .slowClk   (slowClk),
        .stepButton(stepButton),
        .manualMode(manualMode),
        .halt      (halt),
        .cpuClkEn  (n_en),
        .cpuClk    (n_clk),
        .halted    (n_halted),
        .tickCount (n_count)
    );

    always #5 fastClk = ~fastClk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        h          = '{default: 1'b0};
        auto_chk   = 1'b0;
        m_halted   = 1'b0;
        prev_en    = 1'b0;
        streak_hi  = 0;
        pulses     = 0;
        exp_pulses = 0;
        en_err     = 0;
        clk_err    = 0;
        hlt_err    = 0;
    endtask

    task automatic do_reset();
        @(negedge fastClk);
        rst_n      = 1'b0;
        slowClk    = 1'b0;
        stepButton = 1'b0;
        halt       = 1'b0;
        repeat (2) @(negedge fastClk);
        rst_n = 1'b1;
        clear_model();
    endtask

    // One fastClk cycle: drive at negedge, observe 1 ns after posedge, update the model.
    task automatic run(input logic sc, input logic btn);
        logic exp_en;
        @(negedge fastClk);
        slowClk    = sc;
        stepButton = btn;
        @(posedge fastClk);
        #1;
        h[3] = h[2];
        h[2] = h[1];
        h[1] = h[0];
        h[0] = sc;
        streak_hi = btn ? streak_hi + 1 : 0;
        if (cpuClkEn === 1'b1) pulses++;
        if (cpuClkEn === 1'b1 && prev_en === 1'b1) en_err++;
        prev_en = cpuClkEn;
        if (auto_chk) begin
            exp_en = h[2] & ~h[3] & ~m_halted;
            if (exp_en) exp_pulses++;
            if (cpuClkEn !== exp_en) en_err++;
            if (cpuClk !== (h[2] & ~m_halted)) clk_err++;
            if (halted !== m_halted) hlt_err++;
            if (exp_en && halt) m_halted = 1'b1;
        end else if (cpuClkEn === 1'b1) begin
            if (streak_hi < DEB) en_err++;
            if (cpuClk !== 1'b1) clk_err++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge fastClk);
        #1;
        n_cmp++; if (cpuClkEn !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", cpuClkEn); end
        n_cmp++; if (cpuClk !== 1'b0) begin n_bad++; $display("FAIL reset_clk: got %b want 0", cpuClk); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (tickCount !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", tickCount); end
        n_cmp++; if ({n_en, n_clk, n_halted} !== 3'b000 || n_count !== '0) begin
            n_bad++; $display("FAIL reset_narrow: got %b%b%b/%0d want 000/0", n_en, n_clk, n_halted, n_count);
        end
        do_reset();
        repeat (6) run(1'b0, 1'b0);
        n_cmp++; if (pulses !== 0 || tickCount !== '0) begin
            n_bad++; $display("FAIL reset_idle: got %0d pulses count %0d want 0/0", pulses, tickCount);
        end
    endtask

    task automatic test_auto();
        do_reset();
        manualMode = 1'b0;
        repeat (4) run(1'b0, 1'b0);
        auto_chk = 1'b1;
        for (int e = 0; e < 5; e++) begin
            repeat (1000) run(1'b0, 1'b0);
            repeat (1000) run(1'b1, 1'b0);
        end
        n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL auto_pulses: got %0d want 5", pulses); end
        n_cmp++; if (en_err !== 0) begin n_bad++; $display("FAIL auto_timing: got %0d bad cycles want 0", en_err); end
        n_cmp++; if (clk_err !== 0) begin n_bad++; $display("FAIL auto_cpuclk: got %0d bad cycles want 0", clk_err); end
        n_cmp++; if (tickCount !== 16'd5) begin n_bad++; $display("FAIL auto_count: got %0d want 5", tickCount); end
    endtask

    task automatic test_manual();
        do_reset();
        manualMode = 1'b1;
        repeat (6) run(1'b0, 1'b0);
        run(1'b0, 1'b1); run(1'b0, 1'b0); run(1'b0, 1'b1); run(1'b0, 1'b0);
        repeat (10) run(1'b0, 1'b1);
        run(1'b0, 1'b0); run(1'b0, 1'b1);
        repeat (10) run(1'b0, 1'b0);
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL manual_single: got %0d pulses want 1", pulses); end
        n_cmp++; if (tickCount !== 16'd1) begin n_bad++; $display("FAIL manual_count: got %0d want 1", tickCount); end

        for (int p = 0; p < 4; p++) begin
            repeat ($urandom_range(0, 3)) begin
                repeat ($urandom_range(1, DEB - 1)) run(1'b0, 1'b1);
                repeat ($urandom_range(1, DEB - 1)) run(1'b0, 1'b0);
            end
            repeat ($urandom_range(2 * DEB, 30)) run(1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                repeat ($urandom_range(1, DEB - 1)) run(1'b0, 1'b0);
                repeat ($urandom_range(1, DEB - 1)) run(1'b0, 1'b1);
            end
            repeat (3 * DEB) run(1'b0, 1'b0);
        end
        n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL manual_bounce: got %0d pulses want 5", pulses); end

        repeat (1000) run(1'b0, 1'b1);
        n_cmp++; if (cpuClk !== 1'b1) begin n_bad++; $display("FAIL manual_level_held: got %b want 1", cpuClk); end
        repeat (3 * DEB) run(1'b0, 1'b0);
        n_cmp++; if (pulses !== 6) begin n_bad++; $display("FAIL manual_hold: got %0d pulses want 6", pulses); end
        n_cmp++; if (cpuClk !== 1'b0) begin n_bad++; $display("FAIL manual_level_released: got %b want 0", cpuClk); end
        n_cmp++; if (en_err !== 0 || clk_err !== 0) begin
            n_bad++; $display("FAIL manual_shape: got %0d/%0d bad pulses want 0/0", en_err, clk_err);
        end
        n_cmp++; if (tickCount !== 16'd6) begin n_bad++; $display("FAIL manual_count_end: got %0d want 6", tickCount); end
    endtask

    task automatic test_isolation();
        int   half;
        logic sc;
        logic btn;
        do_reset();
        manualMode = 1'b1;
        repeat (6) run(1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            half = $urandom_range(3, 20);
            repeat (half) run(1'b0, 1'b0);
            repeat (half) run(1'b1, 1'b0);
        end
        repeat (4) run(1'b0, 1'b0);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL iso_manual: got %0d pulses want 0", pulses); end

        manualMode = 1'b0;
        repeat (6) run(1'b0, 1'b0);
        auto_chk = 1'b1;
        repeat (2) begin
            repeat (3 * DEB) run(1'b0, 1'b1);
            repeat (3 * DEB) run(1'b0, 1'b0);
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL iso_auto_button: got %0d pulses want 0", pulses); end

        sc  = 1'b0;
        btn = 1'b0;
        repeat (600) begin
            if ($urandom_range(0, 9) == 0) sc = ~sc;
            if ($urandom_range(0, 15) == 0) btn = ~btn;
            run(sc, btn);
        end
        repeat (4) run(1'b0, 1'b0);
        n_cmp++; if (pulses !== exp_pulses) begin n_bad++; $display("FAIL iso_mixed: got %0d pulses want %0d", pulses, exp_pulses); end
        n_cmp++; if (en_err !== 0 || clk_err !== 0) begin
            n_bad++; $display("FAIL iso_timing: got %0d/%0d bad cycles want 0/0", en_err, clk_err);
        end
        n_cmp++; if (tickCount !== CW'(exp_pulses)) begin n_bad++; $display("FAIL iso_count: got %0d want %0d", tickCount, exp_pulses); end
    endtask

    task automatic test_halt();
        int half;
        do_reset();
        manualMode = 1'b0;
        repeat (4) run(1'b0, 1'b0);
        auto_chk = 1'b1;
        for (int r = 0; r < 13; r++) begin
            if (r == 2) halt = 1'b1;
            half = $urandom_range(4, 30);
            repeat (half) run(1'b0, 1'b0);
            repeat (half) run(1'b1, 1'b0);
        end
        repeat (4) run(1'b0, 1'b0);
        n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL halt_pulses: got %0d want 3", pulses); end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_sticky: got %b want 1", halted); end
        n_cmp++; if (cpuClk !== 1'b0) begin n_bad++; $display("FAIL halt_cpuclk: got %b want 0", cpuClk); end
        n_cmp++; if (tickCount !== 16'd3) begin n_bad++; $display("FAIL halt_count: got %0d want 3", tickCount); end
        n_cmp++; if (en_err !== 0 || clk_err !== 0 || hlt_err !== 0) begin
            n_bad++; $display("FAIL halt_timing: got %0d/%0d/%0d bad cycles want 0/0/0", en_err, clk_err, hlt_err);
        end
        @(negedge fastClk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (halted !== 1'b0 || tickCount !== '0) begin
            n_bad++; $display("FAIL halt_reset: got %b/%0d want 0/0", halted, tickCount);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        manualMode = 1'b0;
        repeat (4) run(1'b0, 1'b0);
        auto_chk = 1'b1;
        repeat (256) begin
            repeat (2) run(1'b0, 1'b0);
            repeat (2) run(1'b1, 1'b0);
        end
        repeat (4) run(1'b0, 1'b0);
        n_cmp++; if (n_count !== 8'd0) begin n_bad++; $display("FAIL wrap_to_zero: got %0d want 0", n_count); end
        n_cmp++; if (tickCount !== 16'd256) begin n_bad++; $display("FAIL wrap_wide_256: got %0d want 256", tickCount); end
        repeat (2) run(1'b0, 1'b0);
        repeat (2) run(1'b1, 1'b0);
        repeat (4) run(1'b0, 1'b0);
        n_cmp++; if (n_count !== 8'd1) begin n_bad++; $display("FAIL wrap_to_one: got %0d want 1", n_count); end
        n_cmp++; if (tickCount !== 16'd257) begin n_bad++; $display("FAIL wrap_wide_257: got %0d want 257", tickCount); end
        n_cmp++; if (en_err !== 0) begin n_bad++; $display("FAIL wrap_timing: got %0d bad cycles want 0", en_err); end
    endtask

    task automatic test_async_reset();
        int since;
        int first;
        do_reset();
        manualMode = 1'b0;
        repeat (4) run(1'b0, 1'b0);
        auto_chk = 1'b1;
        repeat (2) begin
            repeat (5) run(1'b0, 1'b0);
            repeat (5) run(1'b1, 1'b0);
        end
        repeat (5) run(1'b0, 1'b0);
        repeat (3) run(1'b1, 1'b0);
        n_cmp++; if (cpuClkEn !== 1'b1 || tickCount !== 16'd2) begin
            n_bad++; $display("FAIL arst_setup: got en %b count %0d want 1/2", cpuClkEn, tickCount);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (cpuClkEn !== 1'b0 || cpuClk !== 1'b0 || tickCount !== '0) begin
            n_bad++; $display("FAIL arst_mid_pulse: got %b/%b/%0d want 0/0/0", cpuClkEn, cpuClk, tickCount);
        end

        slowClk    = 1'b0;
        manualMode = 1'b1;
        stepButton = 1'b1;
        @(negedge fastClk);
        rst_n = 1'b1;
        clear_model();
        repeat (4) run(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (pulses !== 0 || cpuClkEn !== 1'b0 || tickCount !== '0) begin
            n_bad++; $display("FAIL arst_mid_press: got %0d pulses en %b count %0d want 0/0/0", pulses, cpuClkEn, tickCount);
        end

        @(negedge fastClk);
        rst_n = 1'b1;
        clear_model();
        since = 0;
        first = -1;
        repeat (40) begin
            run(1'b0, 1'b1);
            since++;
            if (cpuClkEn === 1'b1 && first < 0) first = since;
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL arst_held_pulses: got %0d want 1", pulses); end
        n_cmp++; if (first < DEB) begin n_bad++; $display("FAIL arst_held_latency: got cycle %0d want >= %0d", first, DEB); end
        n_cmp++; if (tickCount !== 16'd1) begin n_bad++; $display("FAIL arst_held_count: got %0d want 1", tickCount); end
        stepButton = 1'b0;
    endtask

    initial begin
        clear_model();
        test_reset();
        test_auto();
        test_manual();
        test_isolation();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
